// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Holds the FSM state encoding, requester IDs and default widths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int ADDR_W_DEF   = 26;
    localparam int OUT_LOG2_DEF = 3;
    localparam int DATA_W       = 32;
    localparam int BE_W         = 4;

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO of 2^SIZE entries with a wrap bit on each pointer.
// Push when full and pop when empty are ignored; push and pop may coincide.
module fifo #(
    parameter int DBITS = 1,
    parameter int SIZE  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [DBITS-1:0] din,
    output logic [DBITS-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 1 << SIZE;

    logic [SIZE:0]      wr_ptr_q, wr_ptr_d;
    logic [SIZE:0]      rd_ptr_q, rd_ptr_d;
    logic [DBITS-1:0]   mem_q [DEPTH];
    logic [DBITS-1:0]   mem_d [DEPTH];
    logic               do_push;
    logic               do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[SIZE] != rd_ptr_q[SIZE]) &&
                     (wr_ptr_q[SIZE-1:0] == rd_ptr_q[SIZE-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[SIZE-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[SIZE-1:0]] = din;
            wr_ptr_d = wr_ptr_q + (SIZE+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (SIZE+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read once the pointers cover them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester Avalon-MM arbiter onto one memory port, round-robin on ties,
// with a lock to hold the grant and an in-order tag FIFO to route read data.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int OUT_LOG2 = OUT_LOG2_DEF
) (
    input  logic              clock,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_lock,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_lock,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] master_address,
    output logic [BE_W-1:0]   master_byteenable,
    output logic [DATA_W-1:0] master_writedata,
    output logic              master_read,
    output logic              master_write,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_readdatavalid,
    input  logic              master_waitrequest,

    output state_t            dbg_state
);

    // Handshake: a requester holds its command stable while waitrequest is high;
    // a command transfers on a rising edge where it is asserted and waitrequest is low.

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;

    logic               owner_id;
    logic [ADDR_W-1:0]  own_address;
    logic [BE_W-1:0]    own_byteenable;
    logic [DATA_W-1:0]  own_writedata;
    logic               own_read;
    logic               own_write;
    logic               own_lock;
    logic               own_wait;
    logic               accept;

    logic               tag_push;
    logic               tag_pop;
    logic               tag_dout;
    logic               tag_empty;
    logic               tag_full;

    assign owner_id       = (state_q == S_OWN1) ? REQ1 : REQ0;
    assign own_address    = owner_id ? m1_address    : m0_address;
    assign own_byteenable = owner_id ? m1_byteenable : m0_byteenable;
    assign own_writedata  = owner_id ? m1_writedata  : m0_writedata;
    assign own_read       = owner_id ? m1_read       : m0_read;
    assign own_write      = owner_id ? m1_write      : m0_write;
    assign own_lock       = owner_id ? m1_lock       : m0_lock;

    always_comb begin
        state_d           = state_q;
        ptr_d             = ptr_q;
        master_address    = '0;
        master_byteenable = '0;
        master_writedata  = '0;
        master_read       = 1'b0;
        master_write      = 1'b0;
        m0_waitrequest    = 1'b1;
        m1_waitrequest    = 1'b1;
        own_wait          = 1'b1;
        accept            = 1'b0;
        tag_push          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if ((m0_read || m0_write) && (m1_read || m1_write)) begin
                    ptr_d   = (ptr_q == REQ1) ? REQ0 : REQ1;
                    state_d = (ptr_q == REQ1) ? S_OWN0 : S_OWN1;
                end else if (m0_read || m0_write) begin
                    ptr_d   = REQ0;
                    state_d = S_OWN0;
                end else if (m1_read || m1_write) begin
                    ptr_d   = REQ1;
                    state_d = S_OWN1;
                end
            end
            S_OWN0, S_OWN1: begin
                master_address    = own_address;
                master_byteenable = own_byteenable;
                master_writedata  = own_writedata;
                // A combined read+write is forwarded as a write; reads stall while no tag slot is free.
                master_write      = own_write;
                master_read       = own_read && !own_write && !tag_full;
                own_wait          = master_waitrequest || (own_read && !own_write && tag_full);
                if (owner_id == REQ1) begin
                    m1_waitrequest = own_wait;
                end else begin
                    m0_waitrequest = own_wait;
                end
                accept   = (master_read || master_write) && !master_waitrequest;
                tag_push = master_read && !master_waitrequest;
                if (accept) begin
                    if (!own_lock) begin
                        state_d = S_IDLE;
                    end
                end else if (!own_read && !own_write && !own_lock) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= REQ1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Responses come back in issue order, so the oldest tag names the receiver.
    assign tag_pop          = master_readdatavalid && !tag_empty;
    assign m0_readdatavalid = tag_pop && (tag_dout == REQ0);
    assign m1_readdatavalid = tag_pop && (tag_dout == REQ1);
    assign m0_readdata      = master_readdata;
    assign m1_readdata      = master_readdata;
    assign dbg_state        = state_q;

    fifo #(
        .DBITS (1),
        .SIZE  (OUT_LOG2)
    ) u_tag_fifo (
        .clk   (clock),
        .reset (reset),
        .push  (tag_push),
        .pop   (tag_pop),
        .din   (owner_id),
        .dout  (tag_dout),
        .empty (tag_empty),
        .full  (tag_full)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change on the falling edge,
// outputs are compared 1ns later, well before the next rising edge.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 26;

  logic          clock;
  logic          reset;
  logic [AW-1:0] m0_address, m1_address;
  logic          m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [3:0]    m0_byteenable, m1_byteenable;
  logic [31:0]   m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [31:0]   m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] master_address;
  logic [3:0]    master_byteenable;
  logic [31:0]   master_writedata;
  logic          master_read, master_write;
  logic [31:0]   master_readdata;
  logic          master_readdatavalid;
  logic          master_waitrequest;
  state_t        dbg_state;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(AW), .OUT_LOG2(3)) dut (
    .clock(clock), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .master_address(master_address), .master_byteenable(master_byteenable),
    .master_writedata(master_writedata), .master_read(master_read), .master_write(master_write),
    .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
    .master_waitrequest(master_waitrequest),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); #1;
    checks++;
    if ({master_read, master_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid} !== 6'b001100) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 001100", {master_read, master_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid});
    end
    checks++;
    if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, S_IDLE); end
    reset = 1'b0;
  endtask

  task automatic test_tie();
    tick(); m0_address = 5; m0_read = 1'b1; m1_address = 9; m1_read = 1'b1; #1;
    checks++;
    if ({m0_waitrequest, m1_waitrequest, master_read} !== 3'b110 || dbg_state !== S_IDLE) begin
      errors++; $display("FAIL tie_idle got %b st %0d exp 110 st 0", {m0_waitrequest, m1_waitrequest, master_read}, dbg_state);
    end
    tick(); #1;
    checks++;
    if (dbg_state !== S_OWN0 || {master_read, m0_waitrequest, m1_waitrequest} !== 3'b101 || master_address !== 26'd5) begin
      errors++; $display("FAIL tie_grant0 got st %0d %b addr %0h exp st 1 101 addr 5", dbg_state, {master_read, m0_waitrequest, m1_waitrequest}, master_address);
    end
    tick(); m0_read = 1'b0; #1;
    checks++;
    if (dbg_state !== S_IDLE || {master_read, m1_waitrequest} !== 2'b01) begin
      errors++; $display("FAIL tie_bubble got st %0d %b exp st 0 01", dbg_state, {master_read, m1_waitrequest});
    end
    tick(); #1;
    checks++;
    if (dbg_state !== S_OWN1 || {master_read, m0_waitrequest, m1_waitrequest} !== 3'b110 || master_address !== 26'd9) begin
      errors++; $display("FAIL tie_grant1 got st %0d %b addr %0h exp st 2 110 addr 9", dbg_state, {master_read, m0_waitrequest, m1_waitrequest}, master_address);
    end
    tick(); m1_read = 1'b0; master_readdatavalid = 1'b1; master_readdata = 32'h11; #1;
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10 || m0_readdata !== 32'h11) begin
      errors++; $display("FAIL tie_resp0 got %b data %0h exp 10 data 11", {m0_readdatavalid, m1_readdatavalid}, m0_readdata);
    end
    tick(); master_readdata = 32'h22; #1;
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b01 || m1_readdata !== 32'h22) begin
      errors++; $display("FAIL tie_resp1 got %b data %0h exp 01 data 22", {m0_readdatavalid, m1_readdatavalid}, m1_readdata);
    end
    tick(); master_readdatavalid = 1'b0; #1;
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      errors++; $display("FAIL tie_resp_idle got %b exp 00", {m0_readdatavalid, m1_readdatavalid});
    end
  endtask

  task automatic test_lock();
    tick(); m1_write = 1'b1; m1_address = 100; m1_writedata = 32'h00FF00; m1_byteenable = 4'hF; m1_lock = 1'b1;
    master_waitrequest = 1'b1; #1;
    tick(); m0_read = 1'b1; m0_address = 7; #1;
    checks++;
    if (dbg_state !== S_OWN1 || {master_write, m1_waitrequest, m0_waitrequest} !== 3'b111 || master_address !== 26'd100) begin
      errors++; $display("FAIL lock_stall got st %0d %b addr %0d exp st 2 111 addr 100", dbg_state, {master_write, m1_waitrequest, m0_waitrequest}, master_address);
    end
    tick(); master_waitrequest = 1'b0; #1;
    checks++;
    if (dbg_state !== S_OWN1 || {master_write, master_read, m1_waitrequest, m0_waitrequest} !== 4'b1001 ||
        master_writedata !== 32'h00FF00 || master_byteenable !== 4'hF) begin
      errors++; $display("FAIL lock_color got st %0d %b wd %0h be %0h exp st 2 1001 wd ff00 be f", dbg_state,
                         {master_write, master_read, m1_waitrequest, m0_waitrequest}, master_writedata, master_byteenable);
    end
    tick(); m1_address = 104; m1_writedata = 32'h10; m1_lock = 1'b0; #1;
    checks++;
    if (dbg_state !== S_OWN1 || {master_write, m1_waitrequest, m0_waitrequest} !== 3'b101 ||
        master_address !== 26'd104 || master_writedata !== 32'h10) begin
      errors++; $display("FAIL lock_depth got st %0d %b addr %0d wd %0h exp st 2 101 addr 104 wd 10", dbg_state,
                         {master_write, m1_waitrequest, m0_waitrequest}, master_address, master_writedata);
    end
    tick(); m1_write = 1'b0; #1;
    checks++;
    if (dbg_state !== S_IDLE || master_write !== 1'b0) begin
      errors++; $display("FAIL lock_release got st %0d mw %b exp st 0 mw 0", dbg_state, master_write);
    end
    tick(); #1;
    checks++;
    if (dbg_state !== S_OWN0 || {master_read, m0_waitrequest} !== 2'b10 || master_address !== 26'd7) begin
      errors++; $display("FAIL lock_then_m0 got st %0d %b addr %0d exp st 1 10 addr 7", dbg_state, {master_read, m0_waitrequest}, master_address);
    end
    tick(); m0_read = 1'b0; master_readdatavalid = 1'b1; master_readdata = 32'h33; #1;
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10) begin
      errors++; $display("FAIL lock_resp got %b exp 10", {m0_readdatavalid, m1_readdatavalid});
    end
    tick(); master_readdatavalid = 1'b0;
  endtask

  task automatic test_rr_rw();
    tick(); m0_read = 1'b1; m0_write = 1'b1; m0_address = 40; m0_writedata = 32'hAB;
    m1_write = 1'b1; m1_address = 50; m1_writedata = 32'hCD; #1;
    tick(); #1;
    checks++;
    if (dbg_state !== S_OWN1 || master_address !== 26'd50 || {master_write, master_read, m0_waitrequest, m1_waitrequest} !== 4'b1010) begin
      errors++; $display("FAIL rr_grant1 got st %0d addr %0d %b exp st 2 addr 50 1010", dbg_state, master_address,
                         {master_write, master_read, m0_waitrequest, m1_waitrequest});
    end
    tick(); m1_write = 1'b0; #1;
    tick(); #1;
    checks++;
    if (dbg_state !== S_OWN0 || master_address !== 26'd40 || {master_write, master_read, m0_waitrequest} !== 3'b100 ||
        master_writedata !== 32'hAB) begin
      errors++; $display("FAIL rw_write_only got st %0d addr %0d %b wd %0h exp st 1 addr 40 100 wd ab", dbg_state, master_address,
                         {master_write, master_read, m0_waitrequest}, master_writedata);
    end
    tick(); m0_read = 1'b0; m0_write = 1'b0; master_readdatavalid = 1'b1; master_readdata = 32'h44; #1;
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      errors++; $display("FAIL rw_no_tag got %b exp 00", {m0_readdatavalid, m1_readdatavalid});
    end
    tick(); master_readdatavalid = 1'b0;
  endtask

  task automatic test_full();
    tick(); m0_read = 1'b1; m0_lock = 1'b1; m0_address = 26'h200; #1;
    for (int i = 0; i < 8; i++) begin
      tick(); m0_address = 26'h200 + 26'(i); #1;
      checks++;
      if (dbg_state !== S_OWN0 || {master_read, m0_waitrequest} !== 2'b10 || master_address !== 26'h200 + 26'(i)) begin
        errors++; $display("FAIL full_issue%0d got st %0d %b addr %0h exp st 1 10 addr %0h", i, dbg_state,
                           {master_read, m0_waitrequest}, master_address, 26'h200 + 26'(i));
      end
    end
    tick(); m0_address = 26'h208; #1;
    checks++;
    if ({master_read, m0_waitrequest} !== 2'b01) begin
      errors++; $display("FAIL full_stall got %b exp 01", {master_read, m0_waitrequest});
    end
    tick(); master_readdatavalid = 1'b1; master_readdata = 32'h55; #1;
    checks++;
    if ({master_read, m0_waitrequest, m0_readdatavalid, m1_readdatavalid} !== 4'b0110) begin
      errors++; $display("FAIL full_pop_still_stalled got %b exp 0110", {master_read, m0_waitrequest, m0_readdatavalid, m1_readdatavalid});
    end
    tick(); master_readdatavalid = 1'b0; #1;
    checks++;
    if ({master_read, m0_waitrequest} !== 2'b10 || master_address !== 26'h208) begin
      errors++; $display("FAIL full_release got %b addr %0h exp 10 addr 208", {master_read, m0_waitrequest}, master_address);
    end
    tick(); m0_read = 1'b0; m0_lock = 1'b0; #1;
    checks++;
    if (dbg_state !== S_OWN0 || master_read !== 1'b0) begin
      errors++; $display("FAIL full_idle_owner got st %0d mr %b exp st 1 mr 0", dbg_state, master_read);
    end
    tick(); #1;
    checks++;
    if (dbg_state !== S_IDLE) begin errors++; $display("FAIL full_drop_grant got st %0d exp 0", dbg_state); end
    for (int i = 0; i < 8; i++) begin
      master_readdatavalid = 1'b1; master_readdata = 32'h100 + 32'(i); #1;
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10 || m0_readdata !== 32'h100 + 32'(i)) begin
        errors++; $display("FAIL full_drain%0d got %b data %0h exp 10 data %0h", i, {m0_readdatavalid, m1_readdatavalid},
                           m0_readdata, 32'h100 + 32'(i));
      end
      tick();
    end
    master_readdatavalid = 1'b1; #1;
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      errors++; $display("FAIL full_drained_empty got %b exp 00", {m0_readdatavalid, m1_readdatavalid});
    end
    master_readdatavalid = 1'b0;
  endtask

  task automatic test_interleave();
    logic [31:0] resp [3];
    logic [1:0]  exp_v [3];
    resp[0] = 32'hA; resp[1] = 32'hB; resp[2] = 32'hC;
    exp_v[0] = 2'b10; exp_v[1] = 2'b01; exp_v[2] = 2'b10;
    tick(); m0_read = 1'b1; m0_address = 26'h10; #1;
    tick(); #1;
    tick(); m0_read = 1'b0; m1_read = 1'b1; m1_address = 26'h11; #1;
    tick(); #1;
    checks++;
    if (dbg_state !== S_OWN1 || master_read !== 1'b1) begin
      errors++; $display("FAIL il_grant1 got st %0d mr %b exp st 2 mr 1", dbg_state, master_read);
    end
    tick(); m1_read = 1'b0; m0_read = 1'b1; m0_address = 26'h12; #1;
    tick(); #1;
    checks++;
    if (dbg_state !== S_OWN0 || master_address !== 26'h12) begin
      errors++; $display("FAIL il_grant0 got st %0d addr %0h exp st 1 addr 12", dbg_state, master_address);
    end
    tick(); m0_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      master_readdatavalid = 1'b1; master_readdata = resp[i]; #1;
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid} !== exp_v[i] || m0_readdata !== resp[i] || m1_readdata !== resp[i]) begin
        errors++; $display("FAIL il_resp%0d got %b data %0h exp %b data %0h", i, {m0_readdatavalid, m1_readdatavalid},
                           m0_readdata, exp_v[i], resp[i]);
      end
      tick();
    end
    master_readdatavalid = 1'b0;
  endtask

  task automatic test_spurious();
    tick(); master_readdatavalid = 1'b1; master_readdata = 32'hEE; #1;
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      errors++; $display("FAIL spur_drop got %b exp 00", {m0_readdatavalid, m1_readdatavalid});
    end
    tick(); master_readdatavalid = 1'b0; m1_read = 1'b1; m1_address = 26'h77; #1;
    tick(); #1;
    checks++;
    if (dbg_state !== S_OWN1 || master_read !== 1'b1 || master_address !== 26'h77) begin
      errors++; $display("FAIL spur_grant got st %0d mr %b addr %0h exp st 2 mr 1 addr 77", dbg_state, master_read, master_address);
    end
    tick(); m1_read = 1'b0; master_readdatavalid = 1'b1; master_readdata = 32'h77; #1;
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b01 || m1_readdata !== 32'h77) begin
      errors++; $display("FAIL spur_route got %b data %0h exp 01 data 77", {m0_readdatavalid, m1_readdatavalid}, m1_readdata);
    end
    tick(); master_readdatavalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    tick(); m0_read = 1'b1; m0_lock = 1'b1; m0_address = 26'h300; #1;
    for (int i = 1; i <= 3; i++) begin
      tick(); m0_address = 26'h300 + 26'(i); #1;
    end
    tick(); m0_read = 1'b0; m0_lock = 1'b0; reset = 1'b1; #1;
    tick(); reset = 1'b0; #1;
    checks++;
    if (dbg_state !== S_IDLE || {m0_waitrequest, m1_waitrequest, master_read} !== 3'b110) begin
      errors++; $display("FAIL rst_mid_state got st %0d %b exp st 0 110", dbg_state, {m0_waitrequest, m1_waitrequest, master_read});
    end
    for (int i = 0; i < 3; i++) begin
      master_readdatavalid = 1'b1; master_readdata = 32'h400 + 32'(i); #1;
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00 || dbg_state !== S_IDLE) begin
        errors++; $display("FAIL rst_mid_late%0d got %b st %0d exp 00 st 0", i, {m0_readdatavalid, m1_readdatavalid}, dbg_state);
      end
      tick();
    end
    master_readdatavalid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_byteenable = 4'hF; m0_writedata = '0; m0_lock = 1'b0;
    m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_byteenable = 4'hF; m1_writedata = '0; m1_lock = 1'b0;
    master_readdata = '0; master_readdatavalid = 1'b0; master_waitrequest = 1'b0;

    test_reset();
    test_tie();
    test_lock();
    test_rr_rw();
    test_full();
    test_interleave();
    test_spurious();
    test_reset_mid();

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
